// File: rtl/toe_pkg.sv
// Shared types and constants for the TOE transmit arbiter.
// Holds the FSM state enum, channel tags and the channel-full decoder.
package toe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam logic [2:0] CHAN_NONE = 3'd0;
  localparam logic [2:0] CHAN_CMD  = 3'd1;
  localparam logic [2:0] CHAN_IMG  = 3'd2;

  localparam int TO_W = 10;

  // Only the command and image channels report back-pressure.
  function automatic logic chan_full(
    input logic [2:0] c,
    input logic [1:0] full
  );
    logic f;
    unique case (1'b1)
      (c == CHAN_CMD): f = full[0];
      (c == CHAN_IMG): f = full[1];
      default:         f = 1'b0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/toe_tx_arbiter_rr.sv
// Combinational round-robin picker: first eligible index after last.
// Ports: elig/last in; gnt (one-hot), idx, found out.
module toe_tx_arbiter_rr #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin
    int c;
    logic [IW-1:0] ci;
    gnt   = '0;
    idx   = last;
    found = 1'b0;
    c     = 0;
    ci    = '0;
    for (int k = 1; k <= N; k++) begin
      c  = (int'(last) + k) % N;
      ci = IW'(c);
      if (!found && elig[ci]) begin
        found   = 1'b1;
        gnt[ci] = 1'b1;
        idx     = ci;
      end
    end
  end

endmodule

// File: rtl/toe_tx_arbiter.sv
// Frame-level round-robin arbiter for the TOE transmit byte port.
// Ports: src_* per-source frame streams; tx/tx_data/tx_chan to TOE.
module toe_tx_arbiter
  import toe_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 1023
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SRC-1:0]   src_req,
  input  logic [3*NUM_SRC-1:0] src_chan,
  output logic [NUM_SRC-1:0]   src_gnt,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [8*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]   src_last,
  output logic [NUM_SRC-1:0]   src_ready,
  output logic                 tx,
  output logic [7:0]           tx_data,
  output logic [2:0]           tx_chan,
  input  logic [1:0]           tx_full,
  output logic                 busy,
  output logic                 abort
);

  localparam int IW = (NUM_SRC > 2) ? 2 : 1;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] gnt_q, gnt_d;
  logic [2:0]         chan_q, chan_d;
  logic [IW-1:0]      last_q, last_d;
  logic [TO_W-1:0]    wd_q, wd_d;
  logic [3:0]         gap_q, gap_d;
  logic               tx_q, tx_d;
  logic [7:0]         txd_q, txd_d;
  logic               abort_q, abort_d;

  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_ok;
  logic [2:0]         pick_chan;

  logic               cur_full;
  logic               cur_valid;
  logic               cur_last;
  logic [7:0]         cur_data;
  logic               accept;

  always_comb begin
    elig      = '0;
    pick_chan = CHAN_NONE;
    for (int i = 0; i < NUM_SRC; i++) begin
      elig[i] = src_req[i] &
                ~chan_full(src_chan[3*i +: 3], tx_full);
      if (pick_gnt[i]) pick_chan = src_chan[3*i +: 3];
    end
  end

  toe_tx_arbiter_rr #(
    .N  (NUM_SRC),
    .IW (IW)
  ) u_rr (
    .elig  (elig),
    .last  (last_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .found (pick_ok)
  );

  always_comb begin
    cur_full  = chan_full(chan_q, tx_full);
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt_q[i]) begin
        cur_valid = src_valid[i];
        cur_last  = src_last[i];
        cur_data  = src_data[8*i +: 8];
      end
    end
    src_ready = '0;
    if (state_q == ST_XFER && !cur_full) src_ready = gnt_q;
    accept = (state_q == ST_XFER) && !cur_full && cur_valid;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    chan_d  = chan_q;
    last_d  = last_q;
    wd_d    = wd_q;
    gap_d   = gap_q;
    tx_d    = 1'b0;
    txd_d   = txd_q;
    abort_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_ok) begin
          gnt_d   = pick_gnt;
          chan_d  = pick_chan;
          last_d  = pick_idx;
          wd_d    = '0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (accept) begin
          tx_d  = 1'b1;
          txd_d = cur_data;
          wd_d  = '0;
          if (cur_last) begin
            gnt_d   = '0;
            gap_d   = '0;
            state_d = ST_GAP;
          end
        end else if (!cur_full) begin
          // Granted source is starving an open channel.
          if (wd_q == TO_W'(TIMEOUT - 1)) begin
            abort_d = 1'b1;
            gnt_d   = '0;
            gap_d   = '0;
            wd_d    = '0;
            state_d = ST_GAP;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == 4'(GAP_CYCLES - 1)) begin
          gap_d   = '0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      chan_q  <= CHAN_NONE;
      last_q  <= IW'(NUM_SRC - 1);
      wd_q    <= '0;
      gap_q   <= '0;
      tx_q    <= 1'b0;
      txd_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      chan_q  <= chan_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      gap_q   <= gap_d;
      tx_q    <= tx_d;
      txd_q   <= txd_d;
      abort_q <= abort_d;
    end
  end

  assign src_gnt = gnt_q;
  assign tx      = tx_q;
  assign tx_data = txd_q;
  assign tx_chan = (state_q == ST_IDLE) ? CHAN_NONE : chan_q;
  assign busy    = (state_q != ST_IDLE);
  assign abort   = abort_q;

endmodule

// File: doc/toe_tx_arbiter.md
# toe_tx_arbiter

Shares the single TOE transmit byte port (tx / tx_data / tx_chan, back-pressured by tx_full) between several frame sources, e.g. the command-response sender and the image line streamer. It grants whole frames round-robin, forwards bytes with one registered stage, and holds off any frame whose target channel is full. Frames that stall are aborted by a watchdog, and a fixed idle gap is inserted between frames. It sits between the frame producers and the TOE core.

## Interface
- NUM_SRC, 2, number of requesters (2..4)
- GAP_CYCLES, 2, idle cycles forced between frames (1..15)
- TIMEOUT, 1023, stall cycles before abort (10-bit counter, 1..1023)
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- src_req  in  NUM_SRC  source i has a frame pending
- src_chan  in  3*NUM_SRC  target TOE channel of source i, slice [3i+2:3i]
- src_gnt  out  NUM_SRC  one-hot grant, held for the whole frame
- src_valid  in  NUM_SRC  byte valid from source i
- src_data  in  8*NUM_SRC  byte from source i
- src_last  in  NUM_SRC  marks the final byte of the frame
- src_ready  out  NUM_SRC  beat accepted when valid & ready (combinational)
- tx  out  1  byte strobe to TOE
- tx_data  out  8  byte to TOE
- tx_chan  out  3  channel tag; 0 when idle
- tx_full  in  2  bit0 = channel 1 full, bit1 = channel 2 full
- busy  out  1  state != IDLE
- abort  out  1  one-cycle pulse on watchdog abort

## Operation
- States: IDLE, XFER, GAP.
- chan_full(c): c==1 → tx_full[0]; c==2 → tx_full[1]; otherwise 0.
- IDLE:
  - Eligible set = src_req & ~chan_full(src_chan).
  - Pick the first eligible index after last_winner (modulo NUM_SRC).
  - On a pick: latch gnt one-hot, cur_chan = src_chan[pick], last_winner = pick; go to XFER.
  - Nothing eligible: stay in IDLE.
- XFER:
  - src_gnt = gnt; src_ready[g] = ~chan_full(cur_chan); all other ready bits are 0.
  - Beat accepted → tx=1, tx_data=byte, tx_chan=cur_chan on the next cycle.
  - Accepted beat with src_last → GAP.
  - Watchdog counts cycles where src_ready[g] & ~src_valid[g]. It clears on every accepted beat. It does not count while the channel is full.
  - Watchdog reaches TIMEOUT → abort pulse, GAP. No terminating byte is sent.
- GAP: tx=0; count GAP_CYCLES cycles, then go to IDLE.
- src_req dropping during XFER is ignored; the grant releases only on last or abort.
- Source valid/data of ungranted sources are ignored entirely.

## Timing
- Reset values: src_gnt=0, tx=0, tx_data=0, tx_chan=0, busy=0, abort=0, last_winner=NUM_SRC-1 so source 0 wins first, counters=0.
- Reset mid-frame: immediate return to IDLE; the partial frame is not completed.
- Latency:
  - req → src_gnt: 1 clock from IDLE.
  - Accepted beat → tx: 1 clock.
- Maximum throughput is 1 byte per clock.
- Minimum spacing, last accepted byte → next frame's first tx: GAP_CYCLES + 3 clocks.
- tx_full rising mid-frame: ready drops in the same cycle; the frame resumes when full clears.
- Simultaneous requests: strict round-robin; no source is granted twice while another eligible source waits.
- tx_data holds its last value when tx=0.
- tx_chan = cur_chan in XFER and GAP; 0 in IDLE.

## Structure
- Shared package toe_pkg:
  - State encoding (2-bit enum).
  - CHAN_NONE=0, CHAN_CMD=1, CHAN_IMG=2.
  - Watchdog width constant TO_W=10.
- Sub-module rr_arbiter: eligible vector + last_winner in → one-hot grant + index out; purely combinational.
- The FSM, watchdog, gap counter, and output register live in toe_tx_arbiter.

## Test plan
- Single frame: src 0 sends chan 1, 5 bytes 0x11..0x15, last on 0x15 → tx high for 5 consecutive cycles, tx_data 0x11..0x15, tx_chan=1, then 0 after the gap.
- Contention: src 0 and src 1 request continuously with 3-byte frames → grants alternate 0,1,0,1; GAP_CYCLES idle cycles of tx between frames.
- Back-pressure: tx_full[0] asserts for 4 cycles mid-frame on chan 1 → src_ready[0]=0 for exactly those cycles; no byte lost or duplicated; no abort.
- Full at arbitration: tx_full[1]=1, src 0 targets chan 2, src 1 targets chan 1 → src 1 granted first; src 0 granted after tx_full[1] clears.
- Watchdog: src 0 granted, then valid=0 for TIMEOUT cycles → abort pulses once; busy returns to 0 after the gap; src 1 is then grantable.
- Reset mid-frame: rst_n low during byte 3 → all outputs 0 asynchronously; after release, the first grant goes to src 0.
